// File: rtl/lsu_mem_ctrl_if.sv
// Load/store stage bus bundle: execute request, data-memory bus and response to the extractor.
interface lsu_mem_ctrl_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [BE_W-1:0] mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;

  logic            rsp_valid;
  logic [XLEN-1:0] rsp_inst;
  logic [XLEN-1:0] rsp_data;
  logic            misalign_err;
  logic            timeout_err;

  // LSU side
  modport slave (
    input  req_valid, inst, addr, wdata, mem_rdata, mem_ack,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           rsp_valid, rsp_inst, rsp_data, misalign_err, timeout_err
  );

  // Execute / memory / extractor side
  modport master (
    output req_valid, inst, addr, wdata, mem_rdata, mem_ack,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           rsp_valid, rsp_inst, rsp_data, misalign_err, timeout_err
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store memory-access stage: issues one aligned data-memory access per instruction
// and returns the addressed bytes right-justified, with misalign and ack-timeout errors.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input logic          clk,
  input logic          rst,
  lsu_mem_ctrl_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = 4;
  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [1:0]        off_q, off_d;
  logic              is_load_q, is_load_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rsp_inst_q, rsp_inst_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic              misalign_q, misalign_d;
  logic              timeout_q, timeout_d;

  // Decode of the instruction currently offered by execute
  logic [6:0]      opc_c;
  logic [1:0]      size_c;
  logic [1:0]      off_c;
  logic            is_load_c, is_store_c, misalign_c;
  logic [BE_W-1:0] be_c;
  logic [XLEN-1:0] wd_c;

  always_comb begin
    opc_c      = bus.inst[6:0];
    size_c     = bus.inst[13:12];
    off_c      = bus.addr[1:0];
    is_load_c  = (opc_c == OPC_LOAD);
    is_store_c = (opc_c == OPC_STORE);
    misalign_c = 1'b0;
    be_c       = 4'b1111;
    wd_c       = bus.wdata;
    case (size_c)
      2'b00: begin
        be_c = 4'b0001 << off_c;
        wd_c = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        be_c       = 4'b0011 << off_c;
        wd_c       = {2{bus.wdata[15:0]}};
        misalign_c = off_c[0];
      end
      2'b10: misalign_c = (off_c != 2'b00);
      default: misalign_c = 1'b1;
    endcase
    if (!is_store_c) wd_c = '0;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    inst_d      = inst_q;
    wdata_d     = wdata_q;
    off_d       = off_q;
    is_load_d   = is_load_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_inst_d  = rsp_inst_q;
    rsp_data_d  = rsp_data_q;
    misalign_d  = 1'b0;
    timeout_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          inst_d    = bus.inst;
          wdata_d   = bus.wdata;
          off_d     = off_c;
          is_load_d = is_load_c;
          if (!(is_load_c || is_store_c)) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_inst_d  = bus.inst;
            rsp_data_d  = bus.wdata;
          end else if (misalign_c) begin
            state_d     = ERR;
            rsp_valid_d = 1'b1;
            misalign_d  = 1'b1;
            rsp_inst_d  = bus.inst;
            rsp_data_d  = '0;
          end else begin
            state_d     = REQ;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store_c;
            mem_addr_d  = {bus.addr[XLEN-1:2], 2'b00};
            mem_be_d    = be_c;
            mem_wdata_d = wd_c;
          end
        end
      end
      REQ: begin
        // An ack on the final timeout cycle still completes normally
        if (bus.mem_ack) begin
          state_d     = RESP;
          cnt_d       = '0;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_inst_d  = inst_q;
          rsp_data_d  = is_load_q ? (bus.mem_rdata >> {off_q, 3'b000}) : wdata_q;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          state_d     = ERR;
          cnt_d       = '0;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          timeout_d   = 1'b1;
          rsp_inst_d  = inst_q;
          rsp_data_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      inst_q      <= '0;
      wdata_q     <= '0;
      off_q       <= '0;
      is_load_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_inst_q  <= '0;
      rsp_data_q  <= '0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inst_q      <= inst_d;
      wdata_q     <= wdata_d;
      off_q       <= off_d;
      is_load_q   <= is_load_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_inst_q  <= rsp_inst_d;
      rsp_data_q  <= rsp_data_d;
      misalign_q  <= misalign_d;
      timeout_q   <= timeout_d;
    end
  end

  // req_ready is gated by rst so execute sees it drop the moment reset asserts
  assign bus.req_ready    = (state_q == IDLE) && !rst;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_be       = mem_be_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_inst     = rsp_inst_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.misalign_err = misalign_q;
  assign bus.timeout_err  = timeout_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed cases plus random ops against a byte-lane model.
module tb_lsu_mem_ctrl;
  localparam int unsigned TO = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one instruction and follow it to its response; d = REQ cycles before ack (ack in cycle d+1)
  task automatic run_op(input logic [31:0] i, input logic [31:0] a, input logic [31:0] w,
                        input logic [31:0] rd, input int d);
    bit          ld, st, mis, tmo;
    int          nb, off, nreq;
    logic [3:0]  be;
    logic [31:0] mwd, exp_data;
    ld  = (i[6:0] == 7'h03);
    st  = (i[6:0] == 7'h23);
    case (i[13:12])
      2'd0: nb = 1;
      2'd1: nb = 2;
      2'd2: nb = 4;
      default: nb = 0;
    endcase
    off = int'(a[1:0]);
    mis = (ld || st) && ((nb == 0) ? 1'b1 : ((off % nb) != 0));
    be  = '0;
    mwd = '0;
    for (int j = 0; j < 4; j++) begin
      if (j >= off && j < off + nb) be[j] = 1'b1;
      if (st && nb != 0) mwd[8*j +: 8] = w[8*(j % nb) +: 8];
    end

    chk("req_ready_before", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.inst      = i;
    bus.addr      = a;
    bus.wdata     = w;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    bus.inst  = $urandom;
    bus.addr  = $urandom;
    bus.wdata = $urandom;
    @(negedge clk);

    tmo = 1'b0;
    if (!(ld || st) || mis) begin
      exp_data = mis ? 32'd0 : w;
    end else begin
      tmo  = (d + 1 > int'(TO));
      nreq = tmo ? int'(TO) : d + 1;
      for (int k = 1; k <= nreq; k++) begin
        chk("mem_req_hi", 32'(bus.mem_req), 32'd1);
        chk("mem_addr", bus.mem_addr, a & ~32'h3);
        chk("mem_be", 32'(bus.mem_be), 32'(be));
        chk("mem_we", 32'(bus.mem_we), 32'(st));
        chk("mem_wdata", bus.mem_wdata, mwd);
        chk("rsp_valid_wait", 32'(bus.rsp_valid), 32'd0);
        bus.mem_ack   = (k == d + 1);
        bus.mem_rdata = (k == d + 1) ? rd : $urandom;
        @(posedge clk);
        #1 bus.mem_ack = 1'b0;
        @(negedge clk);
      end
      exp_data = tmo ? 32'd0 : (ld ? (rd >> (8 * off)) : w);
    end

    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_mem_req_lo", 32'(bus.mem_req), 32'd0);
    chk("rsp_data", bus.rsp_data, exp_data);
    chk("rsp_inst", bus.rsp_inst, i);
    chk("misalign_err", 32'(bus.misalign_err), 32'(mis));
    chk("timeout_err", 32'(bus.timeout_err), 32'(tmo));
    chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("rsp_valid_pulse", 32'(bus.rsp_valid), 32'd0);
    chk("err_pulse", 32'({bus.misalign_err, bus.timeout_err}), 32'd0);
    chk("rsp_data_hold", bus.rsp_data, exp_data);
    chk("req_ready_after", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] ri;
    logic [6:0]  ro;
    n_cmp = 0;
    n_err = 0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.inst      = '0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(32'h0000_0003, 32'h0000_1003, 32'h0, 32'h80FF_FF00, 0);
    run_op(32'h0000_1023, 32'h0000_2002, 32'h1234_ABCD, 32'hDEAD_BEEF, 2);
    run_op(32'h0000_2003, 32'h0000_3001, 32'h5555_5555, 32'h0, 0);
    run_op(32'h0000_5003, 32'h0000_0010, 32'h0, 32'h1122_3344, 100);
    run_op(32'h0000_5003, 32'h0000_0010, 32'h0, 32'h1122_3344, 3);
    run_op(32'h0000_0033, 32'h0000_0000, 32'hABAB_ABAB, 32'h0, 0);
    run_op(32'h0000_3023, 32'h0000_0004, 32'h0, 32'h0, 0);

    // Stray ack while idle must not produce a response
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("idle_ack_req", 32'(bus.mem_req), 32'd0);

    // Reset in the middle of a request
    bus.req_valid = 1'b1;
    bus.inst      = 32'h0000_2003;
    bus.addr      = 32'h0000_0040;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("async_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("async_rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    run_op(32'h0000_2003, 32'h0000_0000, 32'h0, 32'hA5A5_A5A5, 0);

    // Random mix of loads, stores and bypass ops with varied ack delay
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: ro = 7'h03;
        1: ro = 7'h23;
        default: begin
          ro = 7'($urandom);
          if (ro == 7'h03 || ro == 7'h23) ro = 7'h13;
        end
      endcase
      ri = $urandom;
      ri[6:0] = ro;
      run_op(ri, $urandom, $urandom, $urandom, int'($urandom_range(0, 5)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
